// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

   localparam int N_DIGITS_DEF    = 4;
   localparam int CLK_DIV_DEF     = 50000;
   localparam int DEAD_CYCLES_DEF = 16;

   // Nibble width fed to the downstream decoder.
   localparam int NIB_W = 4;

   // Common-anode drive: a digit is enabled by pulling its line low.
   localparam logic DIGIT_ON = 1'b0;

   // Ceiling log2, never below 1 so counters always have at least one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer: cnt runs 0..CLK_DIV-1, idx steps through the digits on each
// wrap, and the BLANK/SHOW decode is registered so it lines up with cnt.
module seg7_slot_timer
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = N_DIGITS_DEF,
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
   parameter int IW          = clog2(N_DIGITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [IW-1:0] idx,
   output logic          show,
   output logic          slot_end,   // cnt is at its last value
   output logic          frame_end   // current slot is the last of the frame
);

   localparam int CW = clog2(CLK_DIV);

   localparam logic [0:0]    ST_BLANK = 1'b0;
   localparam logic [0:0]    ST_SHOW  = 1'b1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEAD_C   = CW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic [0:0]    ST_RST   = (DEAD_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   logic [CW-1:0] cnt, cnt_nxt;
   logic [IW-1:0] idx_nxt;
   logic [0:0]    state;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = (idx == IDX_LAST);
   assign show      = (state == ST_SHOW);

   // Next counter / digit index values.
   always_comb begin
      cnt_nxt = slot_end ? '0 : cnt + 1'b1;
      idx_nxt = idx;
      if (slot_end) idx_nxt = frame_end ? '0 : idx + 1'b1;
   end

   // Counter, index and state; state is decoded from cnt_nxt so it tracks cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= '0;
         state <= ST_RST;
      end else begin
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         state <= (cnt_nxt < DEAD_C) ? ST_BLANK : ST_SHOW;
      end
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with a valid/ready load port.
// New values sit in a pending register and move to the shadow register only
// at a frame boundary, so a frame never mixes old and new digits.
// Optional: define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = N_DIGITS_DEF,
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NIB_W*N_DIGITS-1:0] iv_data,
   input  logic [N_DIGITS-1:0]       iv_dp,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic [NIB_W-1:0]          ov_nibble,
   output logic [N_DIGITS-1:0]       ov_digit_n,
   output logic                      o_dp,
   output logic                      o_frame
);

   localparam int IW = clog2(N_DIGITS);

   logic [IW-1:0] idx;
   logic          show, slot_end, frame_end;
   logic          accept, xfer, boundary;

   logic [N_DIGITS-1:0][NIB_W-1:0] pend_data, shadow;
   logic [N_DIGITS-1:0]            pend_dp, shadow_dp, lit;

   seg7_slot_timer #(
      .N_DIGITS    (N_DIGITS),
      .CLK_DIV     (CLK_DIV),
      .DEAD_CYCLES (DEAD_CYCLES),
      .IW          (IW)
   ) u_timer (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .idx       (idx),
      .show      (show),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // o_ready doubles as "pending empty", so accept and transfer are exclusive.
   assign boundary = slot_end & frame_end;
   assign accept   = i_valid & o_ready;
   assign xfer     = boundary & ~o_ready;

   // Pending / shadow registers and the handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ready   <= 1'b1;
         pend_data <= '0;
         pend_dp   <= '0;
         shadow    <= '0;
         shadow_dp <= '0;
      end else if (xfer) begin
         shadow    <= pend_data;
         shadow_dp <= pend_dp;
         o_ready   <= 1'b1;
      end else if (accept) begin
         pend_data <= iv_data;
         pend_dp   <= iv_dp;
         o_ready   <= 1'b0;
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   // Digit k is lit when it or any higher digit is nonzero; digit 0 always.
   function automatic logic [N_DIGITS-1:0] lz_mask(
      input logic [N_DIGITS-1:0][NIB_W-1:0] d);
      logic [N_DIGITS-1:0] m;
      logic                any;
      any = 1'b0;
      m   = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         any  = any | (d[k] != '0) | (k == 0);
         m[k] = any;
      end
      return m;
   endfunction

   // Lit mask follows the shadow register; shadow resets to 0 -> digit 0 only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  lit <= N_DIGITS'(1);
      else if (xfer) lit <= lz_mask(pend_data);
   end
`else
   assign lit = '1;
`endif

   // Output registers: one cycle behind the slot counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_nibble  <= '0;
         ov_digit_n <= {N_DIGITS{~DIGIT_ON}};
         o_dp       <= 1'b0;
         o_frame    <= 1'b0;
      end else begin
         // Nibble tracks idx through BLANK too, giving the decoder setup time.
         ov_nibble <= shadow[idx];
         for (int k = 0; k < N_DIGITS; k++)
            ov_digit_n[k] <= (show && lit[k] && (idx == IW'(k))) ? DIGIT_ON : ~DIGIT_ON;
         o_dp    <= show & lit[idx] & shadow_dp[idx];
         o_frame <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (N_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2).
// A cycle model predicts each output set at the clock edge and pushes it to a
// scoreboard queue; the DUT outputs are popped and compared 1 ns later.
// Define SEG7_LZ_BLANK_EN here as well as in the RTL for the suppression build.
module tb_seg7_scan_mux;

   localparam int ND = 4;
   localparam int CD = 8;
   localparam int DC = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [15:0]   iv_data = '0;
   logic [3:0]    iv_dp = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [3:0]    ov_nibble;
   logic [3:0]    ov_digit_n;
   logic          o_dp;
   logic          o_frame;

   seg7_scan_mux #(.N_DIGITS(ND), .CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .iv_data    (iv_data),
      .iv_dp      (iv_dp),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .ov_nibble  (ov_nibble),
      .ov_digit_n (ov_digit_n),
      .o_dp       (o_dp),
      .o_frame    (o_frame)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [3:0] dn;
      logic [3:0] nib;
      logic       dp;
      logic       fr;
      logic       rdy;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // model state
   int         m_cnt, m_idx;
   logic [15:0] m_sh, m_pd;
   logic [3:0]  m_shdp, m_pdp;
   logic        m_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_sh = '0; m_pd = '0; m_shdp = '0; m_pdp = '0; m_rdy = 1'b1;
      q.delete();
   endtask

   function automatic logic [3:0] lit_of(input logic [15:0] v);
      logic [3:0] l;
`ifdef SEG7_LZ_BLANK_EN
      for (int k = 0; k < 4; k++) l[k] = (k == 0) || ((v >> (4 * k)) != 16'h0);
`else
      l = 4'hF;
      if (v == 16'hFFFF) l = 4'hF;
`endif
      return l;
   endfunction

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_edge();
      exp_t       e;
      logic       sh;
      logic [3:0] l;
      sh = (m_cnt >= DC);
      l  = lit_of(m_sh);
      e.dn = 4'hF;
      if (sh && l[m_idx]) e.dn[m_idx] = 1'b0;
      e.nib = m_sh[m_idx*4 +: 4];
      e.dp  = sh && l[m_idx] && m_shdp[m_idx];
      e.fr  = (m_cnt == CD - 1) && (m_idx == ND - 1);
      if (e.fr && !m_rdy) begin
         m_sh = m_pd; m_shdp = m_pdp; m_rdy = 1'b1;
      end else if (i_valid && m_rdy) begin
         m_pd = iv_data; m_pdp = iv_dp; m_rdy = 1'b0;
      end
      if (m_cnt == CD - 1) begin
         m_cnt = 0;
         m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else m_cnt++;
      e.rdy = m_rdy;
      q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge i_clk);
      model_edge();
      #1;
      if (q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("digit_n", ov_digit_n, e.dn);
         check("nibble",  ov_nibble,  e.nib);
         check("dp",      o_dp,       e.dp);
         check("frame",   o_frame,    e.fr);
         check("ready",   o_ready,    e.rdy);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!o_ready && n < 100) begin step(); n++; end
      check(tag, o_ready, 1'b1);
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] dp);
      wait_ready("load_wait");
      iv_data = d; iv_dp = dp; i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      check("ready_low_after_load", o_ready, 1'b0);
   endtask

   initial begin
      int frames, d0_on, n;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_digit_n", ov_digit_n, 4'hF);
      check("rst_nibble",  ov_nibble,  4'h0);
      check("rst_dp",      o_dp,       1'b0);
      check("rst_frame",   o_frame,    1'b0);
      check("rst_ready",   o_ready,    1'b1);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Idle scanning: first slot has 6 lit cycles, one frame pulse per 32.
      frames = 0; d0_on = 0;
      for (int i = 1; i <= 96; i++) begin
         step();
         if (o_frame) frames++;
         if (i <= 8 && ov_digit_n == 4'b1110) d0_on++;
      end
      check("slot0_lit_cycles", d0_on, 6);
      check("frame_pulses", frames, 3);

      // Single load, then let it display for a full frame.
      load(16'h1234, 4'b0000);
      wait_ready("xfer_1234");
      run(40);

      // Backpressure: BBBB must wait for AAAA to reach the shadow register.
      iv_data = 16'hAAAA; iv_dp = 4'b0000; i_valid = 1'b1;
      step();
      check("bp_ready_low", o_ready, 1'b0);
      iv_data = 16'hBBBB;
      wait_ready("bp_release");
      step();
      i_valid = 1'b0;
      check("bp_bbbb_taken", o_ready, 1'b0);
      run(70);

      // Decimal points on digits 0 and 2.
      load(16'h9876, 4'b0101);
      run(70);

      // Leading-zero patterns (fully lit when suppression is disabled).
      load(16'h0030, 4'b1111);
      run(70);
      load(16'h0000, 4'b0001);
      run(70);

      // Random loads.
      for (int r = 0; r < 4; r++) begin
         load(16'($urandom), 4'($urandom));
         run(40);
      end

      // Mid-frame reset with pending full.
      load(16'h5678, 4'b1010);
      n = 0;
      while (!(m_idx == 2 && m_cnt == 5) && n < 64) begin step(); n++; end
      check("reach_idx2_cnt5", n < 64, 1'b1);
      check("pending_full", o_ready, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_digit_n", ov_digit_n, 4'hF);
      check("mid_rst_ready",   o_ready,    1'b1);
      check("mid_rst_nibble",  ov_nibble,  4'h0);
      check("mid_rst_frame",   o_frame,    1'b0);
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run(72);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
